scan_out: RTL
=============

# scan_out

Scan-out controller downstream of the two ping-pong line buffers (buffer 1 / buffer 2, 100 × 24-bit RGB each, 1-cycle registered read). Runs the display raster counters and reads the active line from whichever buffer holds the current row. It emits aligned RGB, data-enable and active-low sync. It hands each buffer back to the writer through a ready/done handshake and substitutes black on underflow.

## Interface
- H_ACTIVE, 100, active pixels per line (≤ 128; buffer depth)
- H_FP / H_SYNC / H_BP, 4 / 8 / 8, horizontal porch and sync widths; H_TOTAL = sum = 120
- V_ACTIVE, 100, active lines per frame
- V_FP / V_SYNC / V_BP, 2 / 2 / 4, vertical porch and sync widths; V_TOTAL = 108
- clock  in  1  single system/pixel clock, all logic on posedge
- reset  in  1  synchronous, active-high
- red_pix1, green_pix1, blue_pix1  in  8 each  buffer 1 read data, valid 1 cycle after RE1
- red_pix2, green_pix2, blue_pix2  in  8 each  buffer 2 read data, valid 1 cycle after RE2
- line_ready  in  2  bit0 = buffer 1 full, bit1 = buffer 2 full (level, from writer)
- RE1, RE2  out  1 each  buffer read enables
- Addr1, Addr2  out  7 each  buffer read addresses
- line_done  out  2  1-cycle pulse; buffer released to writer
- red_out, green_out, blue_out  out  8 each  pixel to display
- de_out  out  1  data enable
- hsync_n, vsync_n  out  1 each  active-low syncs
- underflow  out  1  sticky; set on any starved line

## Operation
- Counters h_cnt 0..H_TOTAL-1 and v_cnt 0..V_TOTAL-1. h wraps to 0 and increments v at H_TOTAL-1. v wraps to 0 at V_TOTAL-1 with h wrap.
- Active region: h_cnt < H_ACTIVE and v_cnt < V_ACTIVE. hsync asserted for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC). vsync uses the same rule on v_cnt.
- sel register (0 = buffer 1, 1 = buffer 2) picks the current line buffer.
- FSM per line: S_WAIT → S_READ or S_STARVE → S_WAIT.
  - S_WAIT: at h_cnt==0 with v_cnt < V_ACTIVE, sample line_ready[sel]. If 1, go to S_READ. If 0, go to S_STARVE and set underflow.
  - S_READ: RE of sel = 1, Addr of sel = h_cnt[6:0] for h_cnt 0..H_ACTIVE-1. At h_cnt==H_ACTIVE-1: pulse line_done[sel] next cycle, toggle sel, return to S_WAIT.
  - S_STARVE: no RE, black pixels, sel unchanged, return to S_WAIT at h_cnt==H_ACTIVE-1. The same buffer is retried on the next line.
- Unselected buffer's RE stays 0. Its Addr holds 0.
- Writer must drop line_ready[i] within 1 cycle of line_done[i]. line_ready rising mid-line is ignored until the next h_cnt==0.
- Pixel mux: outputs take the buffer selected by the delayed sel, gated to 0 when delayed de is 0 or the line is starved.
- underflow clears only on reset.

## Timing
- Reset values: h_cnt = v_cnt = 0, sel = 0, FSM = S_WAIT, RE1/RE2 = 0, Addr1/Addr2 = 0, line_done = 0, RGB = 0, de_out = 0, hsync_n = vsync_n = 1, underflow = 0.
- Reset mid-line drops ownership without a line_done pulse. The writer restarts on buffer 1.
- Read pipeline: RE/Addr in cycle t (from h_cnt), buffer data in t+1, registered RGB in t+2.
- de/hsync/vsync are delayed through a 2-stage shift so every display output lags h_cnt by exactly 2 cycles.
- line_done fires in the cycle after the last RE (h_cnt==H_ACTIVE). The last pixel is still in flight; the buffer does not overwrite it because the writer's first write needs 1 more cycle.

## Structure
- Shared package display_pkg: RGB888 struct, default timing constants (H_ACTIVE…V_TOTAL), ADDR_W = 7, sel encoding.
- Sub-module raster_timing: h/v counters plus raw de/hsync/vsync. It is reused by the writer side.
- scan_out itself contains the FSM, ping-pong select, read port drive, 2-stage align pipe and output mux.

## Test plan
- Reset, line_ready = 2'b11 held (writer re-asserts after each done) → de_out first high 2 cycles after v=0,h=0. Line 0 from buffer 1, line 1 from buffer 2, alternating. 100 de cycles per line, 100 lines per frame.
- Buffer 1 holds pixel value {8'h10+i, 8'h20, 8'h30} at Addr i → red_out sequence 0x10..0x73 with de_out, no gaps.
- line_ready[1] = 0 at start of line 1 → line 1 all black with de_out = 1, underflow = 1. Line 2 reads buffer 2 after ready rises. line_done[0] does not repeat.
- Sync check: hsync_n low 8 cycles starting at delayed h = 104. vsync_n low for lines 102–103. Both high after reset.
- Reset asserted at h = 50 of an active line → next cycle all outputs at reset values, no line_done. Scanning resumes from buffer 1.
- line_done[sel] is a single 1-cycle pulse at h = 100 and never coincides with RE of the same buffer.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display definitions: raster timing constants, pixel type and buffer select encoding.
// Used by both the line-buffer writer and the scan-out side.
package display_pkg;

  localparam int DATA_W   = 8;
  localparam int ADDR_W   = 7;

  localparam int H_ACTIVE = 100;
  localparam int H_FP     = 4;
  localparam int H_SYNC   = 8;
  localparam int H_BP     = 8;
  localparam int H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;

  localparam int V_ACTIVE = 100;
  localparam int V_FP     = 2;
  localparam int V_SYNC   = 2;
  localparam int V_BP     = 4;
  localparam int V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam int H_CNT_W  = $clog2(H_TOTAL);
  localparam int V_CNT_W  = $clog2(V_TOTAL);

  typedef struct packed {
    logic [DATA_W-1:0] r;
    logic [DATA_W-1:0] g;
    logic [DATA_W-1:0] b;
  } rgb888_t;

  typedef enum logic {
    SEL_BUF1 = 1'b0,
    SEL_BUF2 = 1'b1
  } sel_e;

endpackage

// File: rtl/raster_timing.sv
// Free-running horizontal/vertical raster counters with raw (undelayed, active-high)
// data-enable and sync flags decoded straight from the counters.
module raster_timing
  import display_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  output logic [H_CNT_W-1:0] h_cnt,
  output logic [V_CNT_W-1:0] v_cnt,
  output logic               de,
  output logic               hsync,
  output logic               vsync
);

  localparam logic [H_CNT_W-1:0] H_LAST = H_CNT_W'(H_TOTAL - 1);
  localparam logic [V_CNT_W-1:0] V_LAST = V_CNT_W'(V_TOTAL - 1);
  localparam logic [H_CNT_W-1:0] H_ACT  = H_CNT_W'(H_ACTIVE);
  localparam logic [V_CNT_W-1:0] V_ACT  = V_CNT_W'(V_ACTIVE);
  localparam logic [H_CNT_W-1:0] H_SS   = H_CNT_W'(H_ACTIVE + H_FP);
  localparam logic [H_CNT_W-1:0] H_SE   = H_CNT_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [V_CNT_W-1:0] V_SS   = V_CNT_W'(V_ACTIVE + V_FP);
  localparam logic [V_CNT_W-1:0] V_SE   = V_CNT_W'(V_ACTIVE + V_FP + V_SYNC);

  always_ff @(posedge clock) begin
    if (reset) begin
      h_cnt <= '0;
      v_cnt <= '0;
    end else if (h_cnt == H_LAST) begin
      h_cnt <= '0;
      v_cnt <= (v_cnt == V_LAST) ? '0 : v_cnt + 1'b1;
    end else begin
      h_cnt <= h_cnt + 1'b1;
    end
  end

  assign de    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
  assign hsync = (h_cnt >= H_SS) && (h_cnt < H_SE);
  assign vsync = (v_cnt >= V_SS) && (v_cnt < V_SE);

endmodule

// File: rtl/scan_out.sv
// Ping-pong line-buffer scan-out: per-line read/starve FSM, buffer read port drive,
// 2-stage alignment of de/sync with the 1-cycle buffer read, and black fill on underflow.
module scan_out
  import display_pkg::*;
(
  input  logic              clock,
  input  logic              reset,
  input  logic [DATA_W-1:0] red_pix1,
  input  logic [DATA_W-1:0] green_pix1,
  input  logic [DATA_W-1:0] blue_pix1,
  input  logic [DATA_W-1:0] red_pix2,
  input  logic [DATA_W-1:0] green_pix2,
  input  logic [DATA_W-1:0] blue_pix2,
  input  logic [1:0]        line_ready,
  output logic              RE1,
  output logic              RE2,
  output logic [ADDR_W-1:0] Addr1,
  output logic [ADDR_W-1:0] Addr2,
  output logic [1:0]        line_done,
  output logic [DATA_W-1:0] red_out,
  output logic [DATA_W-1:0] green_out,
  output logic [DATA_W-1:0] blue_out,
  output logic              de_out,
  output logic              hsync_n,
  output logic              vsync_n,
  output logic              underflow
);

  typedef enum logic [1:0] {
    S_WAIT   = 2'd0,
    S_READ   = 2'd1,
    S_STARVE = 2'd2
  } state_e;

  localparam logic [H_CNT_W-1:0] H_LAST_ACT = H_CNT_W'(H_ACTIVE - 1);
  localparam logic [V_CNT_W-1:0] V_ACT      = V_CNT_W'(V_ACTIVE);

  function automatic rgb888_t pick_pixel(input logic show, input sel_e s,
                                         input rgb888_t p1, input rgb888_t p2);
    if (!show) return '0;
    return (s == SEL_BUF2) ? p2 : p1;
  endfunction

  logic [H_CNT_W-1:0] h_cnt;
  logic [V_CNT_W-1:0] v_cnt;
  logic               de_p0, hs_p0, vs_p0;
  state_e             state;
  sel_e               sel;
  logic               line_start, ready_sel, line_end, reading, starve_p0;

  raster_timing u_timing (
    .clock (clock),
    .reset (reset),
    .h_cnt (h_cnt),
    .v_cnt (v_cnt),
    .de    (de_p0),
    .hsync (hs_p0),
    .vsync (vs_p0)
  );

  // Stage p0: line decision and read port drive, same cycle as h_cnt.
  // The decision at h_cnt==0 must already drive RE for pixel 0, so it is decoded here
  // rather than waiting for the state register; reset gates it so RE is 0 while held.
  assign line_start = (state == S_WAIT) && (h_cnt == '0) && (v_cnt < V_ACT) && !reset;
  assign ready_sel  = (sel == SEL_BUF2) ? line_ready[1] : line_ready[0];
  assign line_end   = (h_cnt == H_LAST_ACT);
  assign reading    = (state == S_READ) || (line_start && ready_sel);
  assign starve_p0  = (state == S_STARVE) || (line_start && !ready_sel);

  assign RE1   = reading && (sel == SEL_BUF1);
  assign RE2   = reading && (sel == SEL_BUF2);
  assign Addr1 = RE1 ? h_cnt[ADDR_W-1:0] : '0;
  assign Addr2 = RE2 ? h_cnt[ADDR_W-1:0] : '0;

  always_ff @(posedge clock) begin
    if (reset) begin
      state     <= S_WAIT;
      sel       <= SEL_BUF1;
      line_done <= '0;
      underflow <= 1'b0;
    end else begin
      line_done <= '0;
      unique case (state)
        S_WAIT: begin
          if (line_start) begin
            if (ready_sel) begin
              state <= S_READ;
            end else begin
              state     <= S_STARVE;
              underflow <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (line_end) begin
            line_done <= (sel == SEL_BUF2) ? 2'b10 : 2'b01;
            sel       <= (sel == SEL_BUF2) ? SEL_BUF1 : SEL_BUF2;
            state     <= S_WAIT;
          end
        end
        S_STARVE: begin
          if (line_end) state <= S_WAIT;
        end
        default: state <= S_WAIT;
      endcase
    end
  end

  // Stage p1: buffer data arrives; carry de/sync/select/starve alongside it.
  logic    vld_p1, hs_p1, vs_p1, starve_p1;
  sel_e    sel_p1;
  rgb888_t pix_p1;

  always_ff @(posedge clock) begin
    if (reset) begin
      vld_p1    <= 1'b0;
      hs_p1     <= 1'b0;
      vs_p1     <= 1'b0;
      starve_p1 <= 1'b0;
      sel_p1    <= SEL_BUF1;
    end else begin
      vld_p1    <= de_p0;
      hs_p1     <= hs_p0;
      vs_p1     <= vs_p0;
      starve_p1 <= starve_p0;
      sel_p1    <= sel;
    end
  end

  always_comb begin
    pix_p1 = pick_pixel(vld_p1 && !starve_p1, sel_p1,
                        rgb888_t'({red_pix1, green_pix1, blue_pix1}),
                        rgb888_t'({red_pix2, green_pix2, blue_pix2}));
  end

  // Stage p2: registered display outputs, 2 cycles behind h_cnt.
  always_ff @(posedge clock) begin
    if (reset) begin
      red_out   <= '0;
      green_out <= '0;
      blue_out  <= '0;
      de_out    <= 1'b0;
      hsync_n   <= 1'b1;
      vsync_n   <= 1'b1;
    end else begin
      red_out   <= pix_p1.r;
      green_out <= pix_p1.g;
      blue_out  <= pix_p1.b;
      de_out    <= vld_p1;
      hsync_n   <= !hs_p1;
      vsync_n   <= !vs_p1;
    end
  end

endmodule
